// File: rtl/gray_sched_pkg.sv
// Shared types and helpers for the Gray-to-binary conversion scheduler.
// Holds the FSM state encoding and an index-width helper.
package gray_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upward,
// wrapping modulo NREQ, and returns a one-hot grant plus winner index.
module rr_arbiter
    import gray_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  win_o
);

    // First set request after the pointer wins.
    always_comb begin
        int   idx;
        logic found;
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin shared Gray-to-binary converter with valid/ready output.
// GRAY_SCHED_BYPASS_EN: convert the whole word in a single edge.
module gray_conv_sched
    import gray_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   gray_in,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        bin_out,
    output logic [$clog2(NREQ)-1:0] bin_id,
    output logic                    bin_valid,
    input  logic                    bin_ready
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = idw(WIDTH);

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic [NREQ-1:0]  grant_q;
    logic             valid_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_win;
    logic [WIDTH-1:0] gray_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .win_o (arb_win)
    );

    assign gray_sel = gray_in[arb_win*WIDTH +: WIDTH];

`ifdef GRAY_SCHED_BYPASS_EN
    logic [WIDTH-1:0] full_bin;

    // Full XOR chain: binary bit i is the parity of Gray bits above and at i.
    always_comb begin
        full_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            full_bin[i] = ^(gray_q >> i);
        end
    end
`else
    logic [CW-1:0] cnt_q;
    logic          prev_q;
    logic          bit_d;

    // One step of the MSB-first chain; the MSB copies the Gray bit.
    always_comb begin
        bit_d = gray_q[cnt_q];
        if (cnt_q != CW'(WIDTH - 1)) begin
            bit_d = gray_q[cnt_q] ^ prev_q;
        end
    end
`endif

    // Arbitration, capture, conversion sequencing and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            gray_q  <= '0;
            bin_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
`ifndef GRAY_SCHED_BYPASS_EN
            cnt_q   <= '0;
            prev_q  <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gray_q  <= gray_sel;
                        id_q    <= arb_win;
                        ptr_q   <= arb_win;
                        grant_q <= arb_gnt;
                        state_q <= CONV;
`ifndef GRAY_SCHED_BYPASS_EN
                        cnt_q   <= CW'(WIDTH - 1);
`endif
                    end
                end
                CONV: begin
`ifdef GRAY_SCHED_BYPASS_EN
                    bin_q   <= full_bin;
                    valid_q <= 1'b1;
                    state_q <= DONE;
`else
                    bin_q[cnt_q] <= bit_d;
                    prev_q       <= bit_d;
                    if (cnt_q == '0) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (bin_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign bin_out   = bin_q;
    assign bin_id    = id_q;
    assign bin_valid = valid_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Scoreboard bench for gray_conv_sched with WIDTH=4, NREQ=4.
// Set GRAY_SCHED_BYPASS_EN to match a bypass build of the design.
module tb_gray_conv_sched;

    localparam int W = 4;
    localparam int N = 4;
`ifdef GRAY_SCHED_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] gray_in = '0;
    logic         bin_ready = 1'b1;
    logic [N-1:0] grant;
    logic         busy;
    logic [W-1:0] bin_out;
    logic [1:0]   bin_id;
    logic         bin_valid;

    gray_conv_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gray_in   (gray_in),
        .grant     (grant),
        .busy      (busy),
        .bin_out   (bin_out),
        .bin_id    (bin_id),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] bin;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   fails = 0;
    int   seen_n = 0;
    bit   seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Monitor: one scoreboard pop per presented result.
    always @(negedge clk) begin
        if (!bin_valid) begin
            seen = 0;
        end else if (!seen) begin
            seen = 1;
            seen_n++;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bin_id", 32'(bin_id), 32'(e.id));
                chk("bin_out", 32'(bin_out), 32'(e.bin));
            end
        end
    end

    task automatic wait_grant(input logic [3:0] gexp, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant == '0 && k < 20);
        chk({tag, "_grant"}, 32'(grant), 32'(gexp));
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!bin_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("return_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_one(input int id, input logic [3:0] g,
                           input logic [3:0] b, input logic [3:0] rq,
                           input logic [3:0] gexp, input string tag);
        gray_in[id*W +: W] = g;
        exp_q.push_back('{id: 2'(id), bin: b});
        req = rq;
        wait_grant(gexp, tag);
        req = '0;
        wait_valid(tag);
        wait_idle();
    endtask

    initial begin
        int base;
        int k;

        // Reset held with random requests: everything stays zero.
        repeat (5) begin
            @(negedge clk);
            req = 4'($urandom);
            chk("reset_outs",
                32'({grant, busy, bin_out, bin_id, bin_valid}), 32'd0);
        end
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_one(1, 4'b0011, 4'b0010, 4'b0010, 4'b0010, "first_req1");
        run_one(0, 4'b0110, 4'b0100, 4'b0001, 4'b0001, "g0110");
        run_one(0, 4'b1000, 4'b1111, 4'b0001, 4'b0001, "g1000");
        run_one(0, 4'b1011, 4'b1101, 4'b0001, 4'b0001, "g1011");

        // All four requesters, dropped on grant, served 0..3 after reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gray_in = {4'b0010, 4'b0011, 4'b0001, 4'b0000};
        exp_q.push_back('{id: 2'd0, bin: 4'd0});
        exp_q.push_back('{id: 2'd1, bin: 4'd1});
        exp_q.push_back('{id: 2'd2, bin: 4'd2});
        exp_q.push_back('{id: 2'd3, bin: 4'd3});
        base = seen_n;
        req = 4'b1111;
        k = 0;
        while (seen_n - base < 4 && k < 80) begin
            @(negedge clk);
            req = req & ~grant;
            k++;
        end
        chk("rr_results", 32'(seen_n - base), 32'd4);
        req = '0;
        wait_idle();

        // Back-pressure: result held, no new grant, inputs ignored.
        bin_ready = 1'b0;
        gray_in[2*W +: W] = 4'b0111;
        exp_q.push_back('{id: 2'd2, bin: 4'b0101});
        req = 4'b0100;
        wait_grant(4'b0100, "stall");
        req = '0;
        wait_valid("stall");
        req = 4'b1111;
        gray_in = 16'hA5C3;
        repeat (10) begin
            @(negedge clk);
            chk("stall_hold",
                32'({bin_valid, busy, grant, bin_id, bin_out}),
                32'({1'b1, 1'b1, 4'b0000, 2'd2, 4'b0101}));
        end
        req = '0;
        bin_ready = 1'b1;
        @(negedge clk);
        chk("ready_release", 32'({bin_valid, busy}), 32'd0);

        // Reset in flight: outputs clear at once, pointer restarts.
        gray_in[0 +: W] = 4'b0101;
        req = 4'b0001;
        wait_grant(4'b0001, "abort");
        req = '0;
`ifndef GRAY_SCHED_BYPASS_EN
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("async_reset",
            32'({grant, busy, bin_out, bin_id, bin_valid}), 32'd0);
        @(negedge clk);
        chk("reset_hold",
            32'({grant, busy, bin_out, bin_id, bin_valid}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        gray_in[3*W +: W] = 4'b1111;
        run_one(0, 4'b1010, 4'b1100, 4'b1001, 4'b0001, "after_reset");

        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
